pll_lock_supervisor: RTL

Synthesizable multi-channel PLL supervisor for the board shells. Drives each PLL's reset, and tracks its lock output through a synchroniser and debouncer. Detects lock timeout and lock loss, retries a bounded number of times, then latches a fault. Sits beside the harness PLL IP and gates downstream reset release on all_locked.

---
 rtl/pll_sup_pkg.sv | 20 ++
 rtl/pll_sup_channel.sv | 132 +++++++++++++
 rtl/pll_lock_supervisor.sv | 88 ++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared definitions for the PLL lock supervisor.
//   pll_state_t  - per-channel supervisor state encoding
//   ST_*         - state constants (IDLE, PWD, RST, WAIT, LOCKED, FAULT)
//   timer_width  - width of a phase timer able to hold max(a, b)
package pll_sup_pkg;

  typedef logic [2:0] pll_state_t;

  localparam pll_state_t ST_IDLE   = 3'd0;
  localparam pll_state_t ST_PWD    = 3'd1;
  localparam pll_state_t ST_RST    = 3'd2;
  localparam pll_state_t ST_WAIT   = 3'd3;
  localparam pll_state_t ST_LOCKED = 3'd4;
  localparam pll_state_t ST_FAULT  = 3'd5;

  function automatic int timer_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/pll_sup_channel.sv
// pll_sup_channel: supervisor for a single PLL.
// Synchronises the raw lock flag, debounces it, sequences the PLL reset,
// detects lock timeout / lock loss and retries a bounded number of times
// before latching a fault.
// Optional feature macro: PLL_PWD_CTRL_EN (adds pll_pwd and a PWD phase
// ahead of every reset attempt).
// Ports:
//   clk, rst_n   - supervisor clock, async active-low reset
//   enable       - 0 forces IDLE and clears the retry count
//   clr_err      - clears retry count, releases FAULT
//   pll_lock     - raw asynchronous lock flag
//   pll_rst      - PLL reset (active-high)
//   ch_locked    - debounced lock status
//   ch_fault     - fault latched
//   lock_event   - 1-cycle pulse per timeout/loss event
//   pll_pwd      - PLL power-down (PLL_PWD_CTRL_EN only)
module pll_sup_channel
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 8,
  parameter int LOCK_TIMEOUT  = 1000,
  parameter int MAX_RETRY     = 3
`ifdef PLL_PWD_CTRL_EN
  , parameter int PWD_CYCLES  = 8
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clr_err,
  input  logic pll_lock,
  output logic pll_rst,
  output logic ch_locked,
  output logic ch_fault,
  output logic lock_event
`ifdef PLL_PWD_CTRL_EN
  , output logic pll_pwd
`endif
);

`ifdef PLL_PWD_CTRL_EN
  localparam int TMR_W = timer_width(LOCK_TIMEOUT,
                                     (RST_CYCLES > PWD_CYCLES) ? RST_CYCLES : PWD_CYCLES);
  // Every reset attempt starts with a power-down phase.
  localparam pll_state_t ST_RESTART = ST_PWD;
`else
  localparam int TMR_W = timer_width(LOCK_TIMEOUT, RST_CYCLES);
  localparam pll_state_t ST_RESTART = ST_RST;
`endif
  localparam int STB_W = $clog2(STABLE_CYCLES + 1);
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  pll_state_t             state_q, state_d;
  logic [TMR_W-1:0]       timer_q;
  logic [STB_W-1:0]       stab_q;
  logic [RTY_W-1:0]       retry_q;
  logic                   evt;
  logic                   event_q;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    evt     = 1'b0;
    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_RESTART;
`ifdef PLL_PWD_CTRL_EN
      ST_PWD:    if (timer_q == TMR_W'(PWD_CYCLES - 1)) state_d = ST_RST;
`endif
      ST_RST:    if (timer_q == TMR_W'(RST_CYCLES - 1)) state_d = ST_WAIT;
      ST_WAIT: begin
        // A completed stable run wins over a timeout landing on the same cycle.
        if (stab_q == STB_W'(STABLE_CYCLES))             state_d = ST_LOCKED;
        else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1))    evt     = 1'b1;
      end
      ST_LOCKED: if (!lock_s)  evt     = 1'b1;
      ST_FAULT:  if (clr_err)  state_d = ST_RESTART;
      default:                 state_d = ST_IDLE;
    endcase
    if (evt)
      state_d = (retry_q == RTY_W'(MAX_RETRY) && !clr_err) ? ST_FAULT : ST_RESTART;
    // Disable overrides everything and never produces an event.
    if (!enable) begin
      state_d = ST_IDLE;
      evt     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      timer_q <= '0;
      stab_q  <= '0;
      retry_q <= '0;
      event_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pll_lock};
      state_q <= state_d;
      event_q <= evt;

      if (state_d != state_q)
        timer_q <= '0;
      else if (state_q == ST_PWD || state_q == ST_RST || state_q == ST_WAIT)
        timer_q <= timer_q + TMR_W'(1);

      // Consecutive-high run length, only meaningful while waiting for lock.
      if (state_d != state_q || state_q != ST_WAIT || !lock_s)
        stab_q <= '0;
      else if (stab_q != STB_W'(STABLE_CYCLES))
        stab_q <= stab_q + STB_W'(1);

      if (!enable || clr_err)
        retry_q <= '0;
      else if (evt && retry_q != RTY_W'(MAX_RETRY))
        retry_q <= retry_q + RTY_W'(1);
    end
  end

  assign pll_rst    = (state_q != ST_WAIT) && (state_q != ST_LOCKED);
  assign ch_locked  = (state_q == ST_LOCKED);
  assign ch_fault   = (state_q == ST_FAULT);
  assign lock_event = event_q;
`ifdef PLL_PWD_CTRL_EN
  assign pll_pwd    = (state_q == ST_IDLE) || (state_q == ST_PWD) || (state_q == ST_FAULT);
`endif

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: multi-channel PLL reset/lock supervisor.
// One pll_sup_channel per PLL plus the shared event counter and the
// registered all-locked flag used to gate downstream reset release.
// Optional feature macro: PLL_PWD_CTRL_EN (adds pll_pwd and PWD_CYCLES).
// Ports:
//   clk, rst_n   - supervisor clock, async active-low reset
//   enable       - 1 = supervise, 0 = hold all PLLs in reset
//   clr_err      - clear err_cnt and retry counters, release faults
//   pll_lock     - raw PLL lock flags (asynchronous)
//   pll_rst      - per-channel PLL reset (active-high)
//   ch_locked    - per-channel debounced lock
//   ch_fault     - per-channel latched fault
//   all_locked   - registered AND of ch_locked
//   lock_event   - per-channel timeout/loss pulse
//   pll_pwd      - per-channel power-down (PLL_PWD_CTRL_EN only)
//   err_cnt      - saturating count of cycles with any event
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_PLL       = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 8,
  parameter int LOCK_TIMEOUT  = 1000,
  parameter int MAX_RETRY     = 3,
  parameter int ERR_CNT_W     = 3
`ifdef PLL_PWD_CTRL_EN
  , parameter int PWD_CYCLES  = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clr_err,
  input  logic [NUM_PLL-1:0]   pll_lock,
  output logic [NUM_PLL-1:0]   pll_rst,
  output logic [NUM_PLL-1:0]   ch_locked,
  output logic [NUM_PLL-1:0]   ch_fault,
  output logic                 all_locked,
  output logic [NUM_PLL-1:0]   lock_event,
`ifdef PLL_PWD_CTRL_EN
  output logic [NUM_PLL-1:0]   pll_pwd,
`endif
  output logic [ERR_CNT_W-1:0] err_cnt
);

  for (genvar g = 0; g < NUM_PLL; g++) begin : g_ch
    pll_sup_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .RST_CYCLES    (RST_CYCLES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .MAX_RETRY     (MAX_RETRY)
`ifdef PLL_PWD_CTRL_EN
      , .PWD_CYCLES  (PWD_CYCLES)
`endif
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .clr_err    (clr_err),
      .pll_lock   (pll_lock[g]),
      .pll_rst    (pll_rst[g]),
      .ch_locked  (ch_locked[g]),
      .ch_fault   (ch_fault[g]),
      .lock_event (lock_event[g])
`ifdef PLL_PWD_CTRL_EN
      , .pll_pwd  (pll_pwd[g])
`endif
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_locked <= 1'b0;
      err_cnt    <= '0;
    end else begin
      all_locked <= &ch_locked;
      // Clear wins over a simultaneous event; one count per cycle however
      // many channels fire.
      if (clr_err)
        err_cnt <= '0;
      else if (|lock_event && err_cnt != '1)
        err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule
